// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the instruction/data memory port arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;
endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-port memory; data port wins
// ties but yields to a waiting fetch after MAX_D_STREAK consecutive data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              stall_if,
  output logic              stall_mem
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);

  arb_state_e    state, state_nxt;
  logic [SW-1:0] d_streak;
  logic          streak_full, can_grant;
  logic          gnt_i, gnt_d, ack_i, ack_d;

  assign streak_full = (d_streak == SW'(MAX_D_STREAK));
  // The ready-pulse cycle never grants, so a held request and its rival compete
  // fairly on the following cycle.
  assign can_grant   = (state == IDLE) & ~i_ready & ~d_ready;

  always_comb begin
    state_nxt = state;
    gnt_i     = 1'b0;
    gnt_d     = 1'b0;
    ack_i     = 1'b0;
    ack_d     = 1'b0;
    case (state)
      IDLE: if (can_grant) begin
        if (d_req && !(i_req && streak_full)) begin
          gnt_d     = 1'b1;
          state_nxt = BUSY_D;
        end else if (i_req) begin
          gnt_i     = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I: if (m_ack) begin
        ack_i     = 1'b1;
        state_nxt = IDLE;
      end
      BUSY_D: if (m_ack) begin
        ack_d     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_ready <= ack_i;
      d_ready <= ack_d;
      if (gnt_d) begin
        m_req   <= 1'b1;
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
      end else if (gnt_i) begin
        m_req  <= 1'b1;
        m_we   <= 1'b0;
        m_addr <= i_addr;
      end else if (ack_i || ack_d) begin
        m_req <= 1'b0;
        m_we  <= 1'b0;
      end
      if (ack_i)          i_rdata <= m_rdata;
      if (ack_d && !m_we) d_rdata <= m_rdata;
    end
  end

  // Streak only measures how long a fetch has been starved by the data port.
  always_ff @(posedge clk) begin
    if (reset || !i_req || gnt_i) d_streak <= '0;
    else if (gnt_d && !streak_full) d_streak <= d_streak + SW'(1);
  end

  assign stall_if  = i_req & ~i_ready;
  assign stall_mem = d_req & ~d_ready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: table of single-port transactions plus hand sequences for
// arbitration, streak limit, dropped requests and reset mid-access.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ready, d_ready, m_req, m_we, stall_if, stall_mem;

  int nchk = 0, nerr = 0;

  // memory model: ack in the lat-th cycle m_req is high
  int          lat = 1;
  logic        mem_en = 1'b1, ack_force = 1'b0;
  logic [31:0] mdata = '0;
  int          mcnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always @(posedge clk) begin
    if (!m_req || m_ack) mcnt <= 0;
    else                 mcnt <= mcnt + 1;
  end
  assign m_ack   = (mem_en && m_req && mcnt == lat - 1) || ack_force;
  assign m_rdata = mdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    int          lat;
    logic        exp_we;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[5];

  initial begin
    vt[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1, 1'b0, 32'hDEADBEEF};
    vt[1] = '{1'b1, 1'b0, 32'h40, 32'h0,        32'hCAFEF00D, 2, 1'b0, 32'hCAFEF00D};
    vt[2] = '{1'b1, 1'b1, 32'h80, 32'h12345678, 32'h55555555, 3, 1'b1, 32'hCAFEF00D};
    vt[3] = '{1'b0, 1'b0, 32'h20, 32'h0,        32'hA5A5A5A5, 5, 1'b0, 32'hA5A5A5A5};
    vt[4] = '{1'b1, 1'b0, 32'h44, 32'h0,        32'h0BADCAFE, 1, 1'b0, 32'h0BADCAFE};

    reset = 1'b1; i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    tick(); tick();
    chk("rst_state", dut.state, IDLE);
    chk("rst_mreq", {m_req, m_we, i_ready, d_ready}, 4'b0);
    chk("rst_addr_wdata", {m_addr, m_wdata}, 64'h0);
    chk("rst_rdata", {i_rdata, d_rdata}, 64'h0);
    reset = 1'b0;
    tick();

    // table of single-port transactions
    for (int v = 0; v < 5; v++) begin
      lat   = vt[v].lat;
      mdata = vt[v].mdata;
      if (vt[v].is_d) begin
        d_req = 1; d_we = vt[v].we; d_addr = vt[v].addr; d_wdata = vt[v].wdata;
      end else begin
        i_req = 1; i_addr = vt[v].addr;
      end
      #1;
      chk($sformatf("v%0d_stall_req", v), vt[v].is_d ? stall_mem : stall_if, 1'b1);
      tick();
      chk($sformatf("v%0d_grant", v), {m_req, m_we, m_addr}, {1'b1, vt[v].exp_we, vt[v].addr});
      if (vt[v].is_d && vt[v].we) chk($sformatf("v%0d_wdata", v), m_wdata, vt[v].wdata);
      for (int k = 1; k < vt[v].lat; k++) begin
        tick();
        chk($sformatf("v%0d_hold%0d", v, k),
            {m_req, m_we, m_addr, i_ready, d_ready, vt[v].is_d ? stall_mem : stall_if},
            {1'b1, vt[v].exp_we, vt[v].addr, 1'b0, 1'b0, 1'b1});
      end
      tick();
      chk($sformatf("v%0d_ready", v), {i_ready, d_ready, m_req}, {~vt[v].is_d, vt[v].is_d, 1'b0});
      chk($sformatf("v%0d_rdata", v), vt[v].is_d ? d_rdata : i_rdata, vt[v].exp_rdata);
      i_req = 0; d_req = 0; d_we = 0;
      tick();
      chk($sformatf("v%0d_ready_off", v), {i_ready, d_ready}, 2'b00);
    end

    // both ports request together: data first, fetch after the ready pulse
    lat = 1; mdata = 32'h33334444;
    i_req = 1; i_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h40;
    tick();
    chk("both_first_d", {m_req, m_we, m_addr}, {1'b1, 1'b0, 32'h40});
    tick();
    chk("both_d_ready", {d_ready, stall_if}, 2'b11);
    chk("both_d_rdata", d_rdata, 32'h33334444);
    d_req = 0;
    tick();
    chk("both_gap", m_req, 1'b0);
    tick();
    chk("both_then_i", {m_req, m_we, m_addr}, {1'b1, 1'b0, 32'h10});
    tick();
    chk("both_i_ready", {i_ready, i_rdata}, {1'b1, 32'h33334444});
    i_req = 0;
    tick();

    // streak limit: 4 data grants then the fetch gets in
    begin
      int   g = 0;
      logic prev = 1'b0;
      logic [4:0] isd = '0;
      lat = 1; mdata = 32'h0;
      i_req = 1; i_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h100;
      for (int c = 0; c < 60 && g < 5; c++) begin
        tick();
        if (m_req && !prev) begin
          isd[g] = (m_addr == 32'h100);
          if (g == 3) chk("streak_at_4", dut.d_streak, 4);
          if (g == 4) chk("streak_cleared", dut.d_streak, 0);
          g++;
        end
        prev = m_req;
      end
      chk("streak_grant_count", g, 5);
      chk("streak_order", isd, 5'b01111);
      i_req = 0; d_req = 0;
      for (int c = 0; c < 4; c++) tick();
      chk("streak_idle", {dut.state, m_req}, {IDLE, 1'b0});
    end

    // requester drops before ready: still completes and pulses ready
    lat = 2; mdata = 32'h00000077;
    i_req = 1; i_addr = 32'h30;
    tick();
    chk("drop_grant", {m_req, m_addr}, {1'b1, 32'h30});
    i_req = 0;
    tick();
    tick();
    chk("drop_ready", {i_ready, i_rdata}, {1'b1, 32'h77});
    tick();

    // reset mid BUSY_D, late ack must be ignored
    mem_en = 0;
    d_req = 1; d_we = 0; d_addr = 32'h300;
    tick();
    chk("rstmid_busy", {dut.state, m_req}, {BUSY_D, 1'b1});
    tick();
    reset = 1; d_req = 0;
    tick();
    reset = 0;
    chk("rstmid_idle", {dut.state, m_req}, {IDLE, 1'b0});
    tick(); tick();
    ack_force = 1;
    tick();
    ack_force = 0;
    chk("rstmid_no_ready", {d_ready, i_ready, m_req}, 3'b000);
    chk("rstmid_state", dut.state, IDLE);
    tick();
    chk("rstmid_no_ready2", {d_ready, i_ready, m_req}, 3'b000);
    mem_en = 1;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
